// File: rtl/time_set_ctrl.sv
// time_set_ctrl - push-button front end for the 24-h alarm clock load port.
//
// Four raw push-buttons are synchronized (2-FF) and debounced. A rising
// debounced level gives a one-cycle press event. A small edit FSM
// (IDLE -> HOUR -> MIN -> COMMIT) edits a BCD HH:MM buffer. On commit it
// pulses LD_time or LD_alarm for one cycle. Time edits start from the
// running time. Alarm edits start from an internal shadow of the last
// committed alarm.
//
// Optional build macro: TSC_AUTOREPEAT_EN. When defined, holding btn_inc
// in an edit state generates repeat increments: the first comes after
// REPEAT_DELAY cycles, then one every REPEAT_CYCLES cycles.
//
// Ports:
//   clk, reset                    clock; asynchronous active-high reset
//   btn_set_time, btn_set_alarm   raw buttons, start a time / alarm edit
//   btn_inc, btn_next             raw buttons, increment field / advance
//   cur_H1..cur_M0                running time from the clock (BCD)
//   H_in1..M_in0                  edit buffer, drives the clock load bus
//   LD_time, LD_alarm             registered one-cycle load strobes
//   editing                       high in HOUR and MIN
//   edit_field                    0 none, 1 hour, 2 minute
module time_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 4096,
    parameter int REPEAT_DELAY    = 512,
    parameter int REPEAT_CYCLES   = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_set_time,
    input  logic       btn_set_alarm,
    input  logic       btn_inc,
    input  logic       btn_next,
    input  logic [1:0] cur_H1,
    input  logic [3:0] cur_H0,
    input  logic [2:0] cur_M1,
    input  logic [3:0] cur_M0,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [2:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic       editing,
    output logic [1:0] edit_field
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam int B_ST = 0;
    localparam int B_SA = 1;
    localparam int B_INC = 2;
    localparam int B_NXT = 3;

    typedef enum logic [1:0] {S_IDLE, S_HOUR, S_MIN, S_COMMIT} state_t;

    // BCD hour increment, 23 wraps to 00; result is {h1, h0}.
    function automatic logic [5:0] hour_inc(input logic [1:0] h1, input logic [3:0] h0);
        if (h1 == 2'd2 && h0 == 4'd3) return 6'd0;
        else if (h0 == 4'd9)          return {h1 + 2'd1, 4'd0};
        else                          return {h1, h0 + 4'd1};
    endfunction

    // BCD minute increment, 59 wraps to 00; result is {m1, m0}.
    function automatic logic [6:0] minute_inc(input logic [2:0] m1, input logic [3:0] m0);
        if (m1 == 3'd5 && m0 == 4'd9) return 7'd0;
        else if (m0 == 4'd9)          return {m1 + 3'd1, 4'd0};
        else                          return {m1, m0 + 4'd1};
    endfunction

    logic [3:0]            raw, sync1, sync2, lvl, lvl_d, press;
    logic [3:0][DB_W-1:0]  db_cnt;
    state_t                state, state_nxt;
    logic                  target_alarm;
    logic [TO_W-1:0]       to_cnt;
    logic                  in_edit, inc_evt, any_press, timeout_hit;
    logic [1:0]            ed_h1, sh_h1;
    logic [3:0]            ed_h0, sh_h0, ed_m0, sh_m0;
    logic [2:0]            ed_m1, sh_m1;

    assign raw = {btn_next, btn_inc, btn_set_alarm, btn_set_time};

    // Synchronize, debounce, and turn debounced rising edges into press pulses.
    // The counter only runs while the synced input disagrees with the
    // accepted level, so any bounce back restarts the qualification window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            lvl    <= '0;
            lvl_d  <= '0;
            press  <= '0;
            db_cnt <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            lvl_d <= lvl;
            press <= lvl & ~lvl_d;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_cnt[i] <= '0;
                    lvl[i]    <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign in_edit = (state == S_HOUR) || (state == S_MIN);

`ifdef TSC_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_CYCLES) ? REPEAT_DELAY : REPEAT_CYCLES;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_armed, rpt_fire;

    // rpt_armed selects the initial delay versus the steady repeat period.
    assign rpt_fire = in_edit && lvl[B_INC] &&
                      (rpt_armed ? (rpt_cnt == RPT_W'(REPEAT_CYCLES - 1))
                                 : (rpt_cnt == RPT_W'(REPEAT_DELAY - 1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
        end else if (!(in_edit && lvl[B_INC])) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
        end else if (rpt_fire) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b1;
        end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
        end
    end

    assign inc_evt = press[B_INC] | rpt_fire;
`else
    // Repeat parameters are unused without autorepeat.
    if (REPEAT_DELAY < 1 || REPEAT_CYCLES < 1) begin : g_repeat_unused
    end
    assign inc_evt = press[B_INC];
`endif

    assign any_press   = inc_evt | press[B_NXT];
    assign timeout_hit = in_edit && !any_press && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // FSM next state. next beats a same-cycle timeout because it is a press.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (press[B_ST] || press[B_SA]) state_nxt = S_HOUR;
            S_HOUR:   if (press[B_NXT]) state_nxt = S_MIN;
                      else if (timeout_hit) state_nxt = S_IDLE;
            S_MIN:    if (press[B_NXT]) state_nxt = S_COMMIT;
                      else if (timeout_hit) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        editing    = in_edit;
        edit_field = 2'd0;
        if (state == S_HOUR)     edit_field = 2'd1;
        else if (state == S_MIN) edit_field = 2'd2;
    end

    // Edit buffer, alarm shadow, timeout counter and load strobes.
    // An increment is dropped when next arrives in the same cycle, which
    // also keeps the buffer frozen in the cycle before the strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {ed_h1, ed_h0, ed_m1, ed_m0} <= '0;
            {sh_h1, sh_h0, sh_m1, sh_m0} <= '0;
            target_alarm <= 1'b0;
            to_cnt       <= '0;
            LD_time      <= 1'b0;
            LD_alarm     <= 1'b0;
        end else begin
            LD_time  <= (state_nxt == S_COMMIT) && !target_alarm;
            LD_alarm <= (state_nxt == S_COMMIT) && target_alarm;

            if (in_edit && !any_press && !timeout_hit) to_cnt <= to_cnt + 1'b1;
            else                                       to_cnt <= '0;

            case (state)
                S_IDLE: begin
                    if (press[B_ST]) begin
                        {ed_h1, ed_h0, ed_m1, ed_m0} <= {cur_H1, cur_H0, cur_M1, cur_M0};
                        target_alarm <= 1'b0;
                    end else if (press[B_SA]) begin
                        {ed_h1, ed_h0, ed_m1, ed_m0} <= {sh_h1, sh_h0, sh_m1, sh_m0};
                        target_alarm <= 1'b1;
                    end
                end
                S_HOUR:   if (inc_evt && !press[B_NXT]) {ed_h1, ed_h0} <= hour_inc(ed_h1, ed_h0);
                S_MIN:    if (inc_evt && !press[B_NXT]) {ed_m1, ed_m0} <= minute_inc(ed_m1, ed_m0);
                default:  if (target_alarm) {sh_h1, sh_h0, sh_m1, sh_m0} <= {ed_h1, ed_h0, ed_m1, ed_m0};
            endcase
        end
    end

    assign H_in1 = ed_h1;
    assign H_in0 = ed_h0;
    assign M_in1 = ed_m1;
    assign M_in0 = ed_m0;

endmodule

// File: tb/tb_time_set_ctrl.sv
module tb_time_set_ctrl;

    localparam int DB = 4;
    localparam int TO = 128;
    localparam int RD = 16;
    localparam int RC = 8;

    typedef struct packed {
        logic        alarm;
        logic [12:0] bus;
    } strobe_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn = 4'd0;   // {next, inc, set_alarm, set_time}
    logic [1:0] cur_H1 = 2'd0;
    logic [3:0] cur_H0 = 4'd0;
    logic [2:0] cur_M1 = 3'd0;
    logic [3:0] cur_M0 = 4'd0;
    logic [1:0] H_in1;
    logic [3:0] H_in0;
    logic [2:0] M_in1;
    logic [3:0] M_in0;
    logic       LD_time, LD_alarm, editing;
    logic [1:0] edit_field;

    int n_cmp = 0;
    int n_err = 0;
    int both_cnt = 0;
    int wide_cnt = 0;
    bit prev_ld = 1'b0;
    strobe_t exp_q[$];
    strobe_t obs_q[$];

    localparam logic [3:0] K_ST  = 4'b0001;
    localparam logic [3:0] K_SA  = 4'b0010;
    localparam logic [3:0] K_INC = 4'b0100;
    localparam logic [3:0] K_NXT = 4'b1000;

    time_set_ctrl #(
        .DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO),
        .REPEAT_DELAY(RD), .REPEAT_CYCLES(RC)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_set_time(btn[0]), .btn_set_alarm(btn[1]),
        .btn_inc(btn[2]), .btn_next(btn[3]),
        .cur_H1(cur_H1), .cur_H0(cur_H0), .cur_M1(cur_M1), .cur_M0(cur_M0),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm),
        .editing(editing), .edit_field(edit_field)
    );

    always #5 clk = ~clk;

    wire [12:0] dut_bus = {H_in1, H_in0, M_in1, M_in0};

    function automatic logic [12:0] bus_of(input int h, input int m);
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
    endfunction

    // Strobe monitor: records every LD cycle and flags overlap / stretching.
    always @(negedge clk) begin
        if (reset) begin
            prev_ld = 1'b0;
        end else begin
            if (LD_time && LD_alarm) both_cnt++;
            if ((LD_time || LD_alarm) && prev_ld) wide_cnt++;
            if (LD_time || LD_alarm) obs_q.push_back({LD_alarm, dut_bus});
            prev_ld = LD_time || LD_alarm;
        end
    end

    task automatic press(input logic [3:0] mask, input int hold);
        @(posedge clk); #1 btn = mask;
        repeat (hold) @(posedge clk);
        #1 btn = 4'd0;
        repeat (DB + 6) @(posedge clk);
        #1;
    endtask

    task automatic tap(input logic [3:0] mask);
        press(mask, DB + 1);
    endtask

    task automatic wait_obs(output bit ok);
        for (int i = 0; i < 64 && obs_q.size() == 0; i++) @(negedge clk);
        ok = (obs_q.size() != 0);
    endtask

    task automatic set_cur(input int h, input int m);
        {cur_H1, cur_H0, cur_M1, cur_M0} = bus_of(h, m);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({dut_bus, LD_time, LD_alarm, editing, edit_field} !== 18'd0) begin
            n_err++; $display("FAIL reset_hold: got bus=%h ld=%b%b ed=%b fld=%0d, required all 0", dut_bus, LD_time, LD_alarm, editing, edit_field); end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if ({dut_bus, LD_time, LD_alarm, editing, edit_field} !== 18'd0) begin
            n_err++; $display("FAIL reset_release: got bus=%h ld=%b%b ed=%b fld=%0d, required all 0", dut_bus, LD_time, LD_alarm, editing, edit_field); end
    endtask

    task automatic test_set_time;
        bit ok;
        strobe_t e, o;
        set_cur(13, 45);
        tap(K_ST);
        n_cmp++; if ({editing, edit_field, dut_bus} !== {1'b1, 2'd1, bus_of(13, 45)}) begin
            n_err++; $display("FAIL set_time_load: got ed=%b fld=%0d bus=%h, required 1/1/%h", editing, edit_field, dut_bus, bus_of(13, 45)); end
        repeat (3) tap(K_INC);
        n_cmp++; if (dut_bus !== bus_of(16, 45)) begin
            n_err++; $display("FAIL set_time_hour: got %h required %h", dut_bus, bus_of(16, 45)); end
        tap(K_NXT);
        n_cmp++; if (edit_field !== 2'd2) begin
            n_err++; $display("FAIL set_time_field: got %0d required 2", edit_field); end
        repeat (2) tap(K_INC);
        n_cmp++; if (dut_bus !== bus_of(16, 47)) begin
            n_err++; $display("FAIL set_time_min: got %h required %h", dut_bus, bus_of(16, 47)); end
        exp_q.push_back({1'b0, bus_of(16, 47)});
        tap(K_NXT);
        wait_obs(ok);
        n_cmp++;
        if (!ok) begin
            n_err++; $display("FAIL set_time_commit: got no strobe, required LD_time");
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin
                n_err++; $display("FAIL set_time_strobe: got alarm=%b bus=%h, required alarm=%b bus=%h", o.alarm, o.bus, e.alarm, e.bus); end
        end
        n_cmp++; if (editing !== 1'b0) begin
            n_err++; $display("FAIL set_time_idle: got editing=%b required 0", editing); end
    endtask

    task automatic test_wrap;
        bit ok;
        strobe_t e, o;
        tap(K_SA);
        n_cmp++; if (dut_bus !== bus_of(0, 0)) begin
            n_err++; $display("FAIL alarm_preload0: got %h required %h", dut_bus, bus_of(0, 0)); end
        for (int h = 1; h <= 23; h++) begin
            tap(K_INC);
            n_cmp++; if (dut_bus !== bus_of(h, 0)) begin
                n_err++; $display("FAIL hour_seq: got %h required %h", dut_bus, bus_of(h, 0)); end
        end
        tap(K_NXT);
        for (int m = 1; m <= 59; m++) begin
            tap(K_INC);
            n_cmp++; if (dut_bus !== bus_of(23, m)) begin
                n_err++; $display("FAIL min_seq: got %h required %h", dut_bus, bus_of(23, m)); end
        end
        exp_q.push_back({1'b1, bus_of(23, 59)});
        tap(K_NXT);
        tap(K_SA);
        n_cmp++; if (dut_bus !== bus_of(23, 59)) begin
            n_err++; $display("FAIL alarm_preload2359: got %h required %h", dut_bus, bus_of(23, 59)); end
        tap(K_INC);
        n_cmp++; if (dut_bus !== bus_of(0, 59)) begin
            n_err++; $display("FAIL hour_wrap: got %h required %h", dut_bus, bus_of(0, 59)); end
        tap(K_NXT);
        tap(K_INC);
        n_cmp++; if (dut_bus !== bus_of(0, 0)) begin
            n_err++; $display("FAIL min_wrap: got %h required %h", dut_bus, bus_of(0, 0)); end
        exp_q.push_back({1'b1, bus_of(0, 0)});
        tap(K_NXT);
        tap(K_SA);
        n_cmp++; if (dut_bus !== bus_of(0, 0)) begin
            n_err++; $display("FAIL alarm_preload_after_wrap: got %h required %h", dut_bus, bus_of(0, 0)); end
        exp_q.push_back({1'b1, bus_of(0, 0)});
        tap(K_NXT);
        tap(K_NXT);
        while (exp_q.size() != 0) begin
            wait_obs(ok);
            n_cmp++;
            if (!ok) begin
                n_err++; $display("FAIL wrap_commit: got no strobe, required %0d more", exp_q.size());
                exp_q.delete();
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                n_cmp++; if (o !== e) begin
                    n_err++; $display("FAIL wrap_strobe: got alarm=%b bus=%h, required alarm=%b bus=%h", o.alarm, o.bus, e.alarm, e.bus); end
            end
        end
    endtask

    task automatic test_debounce;
        int cnt;
        set_cur(13, 45);
        tap(K_ST);
        press(K_INC, DB - 1);
        n_cmp++; if (dut_bus !== bus_of(13, 45)) begin
            n_err++; $display("FAIL short_glitch: got %h required %h", dut_bus, bus_of(13, 45)); end
        @(posedge clk); #1 btn = K_INC;
        @(posedge clk);
        repeat (DB - 1) @(posedge clk);
        #1 btn = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (dut_bus !== bus_of(13, 45)) begin
            n_err++; $display("FAIL latency_early: got %h required %h", dut_bus, bus_of(13, 45)); end
        @(posedge clk); #1;
        n_cmp++; if (dut_bus !== bus_of(14, 45)) begin
            n_err++; $display("FAIL latency_edge: got %h required %h", dut_bus, bus_of(14, 45)); end
        repeat (DB + 6) @(posedge clk);
        #1;
        n_cmp++; if (dut_bus !== bus_of(14, 45)) begin
            n_err++; $display("FAIL single_inc: got %h required %h", dut_bus, bus_of(14, 45)); end
        cnt = 0;
        while (editing && cnt < 2 * TO) begin @(posedge clk); #1; cnt++; end
        n_cmp++; if ({editing, dut_bus} !== {1'b0, bus_of(14, 45)} || obs_q.size() != 0) begin
            n_err++; $display("FAIL timeout_keep: got ed=%b bus=%h strobes=%0d, required 0/%h/0", editing, dut_bus, obs_q.size(), bus_of(14, 45)); end
    endtask

    task automatic test_timeout;
        int cnt;
        tap(K_ST);
        cnt = 0;
        while (editing && cnt < 2 * TO) begin @(posedge clk); #1; cnt++; end
        n_cmp++; if (cnt !== TO - DB - 3) begin
            n_err++; $display("FAIL timeout_cycles: got %0d required %0d", cnt, TO - DB - 3); end
        n_cmp++; if ({editing, edit_field, LD_time, LD_alarm} !== 5'd0 || obs_q.size() != 0) begin
            n_err++; $display("FAIL timeout_idle: got ed=%b fld=%0d strobes=%0d, required 0/0/0", editing, edit_field, obs_q.size()); end
    endtask

    task automatic test_priority;
        bit ok;
        strobe_t e, o;
        tap(K_INC);
        tap(K_NXT);
        n_cmp++; if (editing !== 1'b0 || obs_q.size() != 0) begin
            n_err++; $display("FAIL idle_ignore: got ed=%b strobes=%0d, required 0/0", editing, obs_q.size()); end
        set_cur(9, 30);
        tap(K_ST | K_SA);
        n_cmp++; if (dut_bus !== bus_of(9, 30)) begin
            n_err++; $display("FAIL set_prio_load: got %h required %h", dut_bus, bus_of(9, 30)); end
        tap(K_INC | K_NXT);
        n_cmp++; if ({edit_field, dut_bus} !== {2'd2, bus_of(9, 30)}) begin
            n_err++; $display("FAIL inc_next_prio: got fld=%0d bus=%h, required 2/%h", edit_field, dut_bus, bus_of(9, 30)); end
        exp_q.push_back({1'b0, bus_of(9, 30)});
        tap(K_NXT);
        wait_obs(ok);
        n_cmp++;
        if (!ok) begin
            n_err++; $display("FAIL prio_commit: got no strobe, required LD_time");
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin
                n_err++; $display("FAIL prio_strobe: got alarm=%b bus=%h, required alarm=%b bus=%h", o.alarm, o.bus, e.alarm, e.bus); end
        end
    endtask

    task automatic test_reset_mid_edit;
        bit ok;
        strobe_t e, o;
        tap(K_SA);
        tap(K_INC);
        exp_q.push_back({1'b1, bus_of(1, 0)});
        tap(K_NXT);
        tap(K_NXT);
        wait_obs(ok);
        n_cmp++;
        if (!ok) begin
            n_err++; $display("FAIL alarm01_commit: got no strobe, required LD_alarm");
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin
                n_err++; $display("FAIL alarm01_strobe: got alarm=%b bus=%h, required alarm=%b bus=%h", o.alarm, o.bus, e.alarm, e.bus); end
        end
        tap(K_SA);
        n_cmp++; if (dut_bus !== bus_of(1, 0)) begin
            n_err++; $display("FAIL shadow_01: got %h required %h", dut_bus, bus_of(1, 0)); end
        tap(K_NXT);
        @(negedge clk); #2 reset = 1'b1;
        #1;
        n_cmp++; if ({dut_bus, LD_time, LD_alarm, editing, edit_field} !== 18'd0) begin
            n_err++; $display("FAIL reset_mid_edit: got bus=%h ld=%b%b ed=%b fld=%0d, required all 0", dut_bus, LD_time, LD_alarm, editing, edit_field); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tap(K_SA);
        n_cmp++; if (dut_bus !== bus_of(0, 0) || obs_q.size() != 0) begin
            n_err++; $display("FAIL shadow_after_reset: got bus=%h strobes=%0d, required %h/0", dut_bus, obs_q.size(), bus_of(0, 0)); end
        exp_q.push_back({1'b1, bus_of(0, 0)});
        tap(K_NXT);
        tap(K_NXT);
        wait_obs(ok);
        n_cmp++;
        if (!ok) begin
            n_err++; $display("FAIL post_reset_commit: got no strobe, required LD_alarm");
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin
                n_err++; $display("FAIL post_reset_strobe: got alarm=%b bus=%h, required alarm=%b bus=%h", o.alarm, o.bus, e.alarm, e.bus); end
        end
    endtask

    task automatic test_hold_inc;
        bit ok;
        int exp_m;
        strobe_t e, o;
`ifdef TSC_AUTOREPEAT_EN
        exp_m = 50;
`else
        exp_m = 46;
`endif
        set_cur(13, 45);
        tap(K_ST);
        tap(K_NXT);
        press(K_INC, RD + 3 * RC);
        n_cmp++; if (dut_bus !== bus_of(13, exp_m)) begin
            n_err++; $display("FAIL hold_inc: got %h required %h", dut_bus, bus_of(13, exp_m)); end
        exp_q.push_back({1'b0, bus_of(13, exp_m)});
        tap(K_NXT);
        wait_obs(ok);
        n_cmp++;
        if (!ok) begin
            n_err++; $display("FAIL hold_commit: got no strobe, required LD_time");
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin
                n_err++; $display("FAIL hold_strobe: got alarm=%b bus=%h, required alarm=%b bus=%h", o.alarm, o.bus, e.alarm, e.bus); end
        end
    endtask

    task automatic test_strobe_integrity;
        n_cmp++; if (both_cnt != 0 || wide_cnt != 0) begin
            n_err++; $display("FAIL strobe_shape: got both=%0d wide=%0d, required 0/0", both_cnt, wide_cnt); end
        n_cmp++; if (obs_q.size() != 0 || exp_q.size() != 0) begin
            n_err++; $display("FAIL strobe_balance: got extra_obs=%0d pending_exp=%0d, required 0/0", obs_q.size(), exp_q.size()); end
    endtask

    initial begin
        test_reset;
        test_set_time;
        test_wrap;
        test_debounce;
        test_timeout;
        test_priority;
        test_reset_mid_edit;
        test_hold_inc;
        test_strobe_integrity;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
